mmio_slave_decoder: RTL and testbench

Upstream bridge between the CPU load/store port and the memory-mapped peripherals (GPIO and siblings). Accepts one CPU request at a time over a valid/ready handshake and decodes the address into one of `NUM_SLAVES` fixed windows. Drives a single-cycle `we` or `re` strobe plus write data to the selected peripheral, captures its combinational read data, and returns a registered response to the CPU.

---
 rtl/mmio_slave_decoder.sv | 142 ++++++++++++++
 tb/tb_mmio_slave_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_slave_decoder.sv
// mmio_slave_decoder: bridges one CPU load/store request at a time onto NUM_SLAVES
// fixed, equally sized peripheral windows starting at BASE_ADDR.
// Each transaction is IDLE -> ACCESS (one-cycle we/re strobe) -> RESP (held until taken).
// Optional feature macro: MMIO_DECODE_ERR_EN. When it is defined, misses and misaligned
// accesses report resp_err and loads that miss return 32'hDEAD_BEEF.
module mmio_slave_decoder #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned SLOT_SHIFT = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [NUM_SLAVES-1:0]    sl_we,
    output logic [NUM_SLAVES-1:0]    sl_re,
    output logic [31:0]              sl_wdata,
    input  logic [32*NUM_SLAVES-1:0] sl_rdata
);

    localparam int unsigned SlotW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [63:0] WinSpan = 64'(NUM_SLAVES) << SLOT_SHIFT;

`ifdef MMIO_DECODE_ERR_EN
    localparam bit          ErrEn     = 1'b1;
    localparam logic [31:0] MissRdata = 32'hDEAD_BEEF;
`else
    localparam bit          ErrEn     = 1'b0;
    localparam logic [31:0] MissRdata = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e             state_q;
    logic               write_q;
    logic               hit_q;
    logic [SlotW-1:0]   slot_q;

    logic [31:0]           dec_off;
    logic                  dec_hit;
    logic [SlotW-1:0]      dec_slot;
    logic [NUM_SLAVES-1:0] dec_onehot;
    logic [31:0]           rd_sel;

    assign req_ready = (state_q == StIdle);

    // Address decode of the live request; only consumed on the accepting edge.
    // BASE_ADDR is window aligned and WinSpan is a multiple of 4, so using the full
    // address gives the same hit/slot as decoding with req_addr[1:0] forced to zero.
    always_comb begin
        dec_off  = req_addr - BASE_ADDR;
        dec_hit  = ({32'b0, dec_off} < WinSpan);
`ifdef MMIO_DECODE_ERR_EN
        if (req_addr[1:0] != 2'b00) begin
            dec_hit = 1'b0;
        end
`endif
        dec_slot = SlotW'(dec_off >> SLOT_SHIFT);
        dec_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            dec_onehot[i] = dec_hit && (dec_slot == SlotW'(i));
        end
    end

    // Read-data mux for the slot latched at acceptance.
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == SlotW'(i)) begin
                rd_sel = sl_rdata[32*i +: 32];
            end
        end
    end

    // Transaction FSM with registered strobes and response; async reset drops everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            hit_q      <= 1'b0;
            slot_q     <= '0;
            sl_we      <= '0;
            sl_re      <= '0;
            sl_wdata   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_q  <= StAccess;
                        write_q  <= req_write;
                        hit_q    <= dec_hit;
                        slot_q   <= dec_slot;
                        sl_we    <= req_write ? dec_onehot : '0;
                        sl_re    <= req_write ? '0 : dec_onehot;
                        sl_wdata <= req_write ? req_wdata : '0;
                    end
                end
                StAccess: begin
                    state_q    <= StResp;
                    sl_we      <= '0;
                    sl_re      <= '0;
                    sl_wdata   <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= ErrEn & ~hit_q;
                    if (write_q) begin
                        resp_rdata <= '0;
                    end else if (hit_q) begin
                        resp_rdata <= rd_sel;
                    end else begin
                        resp_rdata <= MissRdata;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_slave_decoder.sv
// Self-checking bench for mmio_slave_decoder: directed table, reset/stall sequences and
// a random stream compared against an arithmetic decode model.
module tb_mmio_slave_decoder;

    localparam int unsigned NS    = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned SHIFT = 12;

`ifdef MMIO_DECODE_ERR_EN
    localparam bit          ErrEn = 1'b1;
    localparam logic [31:0] MissRd = 32'hDEAD_BEEF;
`else
    localparam bit          ErrEn = 1'b0;
    localparam logic [31:0] MissRd = 32'h0000_0000;
`endif

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic [NS-1:0]   sl_we;
    logic [NS-1:0]   sl_re;
    logic [31:0]     sl_wdata;
    logic [32*NS-1:0] sl_rdata;

    logic [31:0] periph_val [NS];

    int vectors;
    int miscompares;
    int n_checks;
    int strobe_seen;
    int hits_expected;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] periph;
        int          delay;
        int          exp_slot;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [9];

    mmio_slave_decoder #(
        .NUM_SLAVES (NS),
        .BASE_ADDR  (BASE),
        .SLOT_SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .sl_we      (sl_we),
        .sl_re      (sl_re),
        .sl_wdata   (sl_wdata),
        .sl_rdata   (sl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripherals: combinational read data, zero unless their read strobe is high.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            sl_rdata[32*i +: 32] = sl_re[i] ? periph_val[i] : 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // At most one strobe bit in any cycle.
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if ($countones({sl_we, sl_re}) > 1) begin
                miscompares++;
                $display("FAIL onehot: got we=%b re=%b expected at most one bit", sl_we, sl_re);
            end
        end
    end

    // Reference decode: window index from plain offset arithmetic, -1 for a miss.
    function automatic int model_slot(input logic [31:0] addr);
        logic [31:0]     o;
        longint unsigned off;
        longint unsigned win;
        o   = addr - BASE;
        off = 64'(o);
        win = 64'(1) << SHIFT;
        if (ErrEn && (addr % 4 != 0)) return -1;
        if (off < longint'(NS) * win) return int'(off / win);
        return -1;
    endfunction

    // Runs one transaction starting from a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_txn(input vec_t v);
        logic [NS-1:0] exp_oh;
        exp_oh = '0;
        for (int i = 0; i < NS; i++) begin
            if (i == v.exp_slot) exp_oh[i] = 1'b1;
            periph_val[i] = (i == v.exp_slot) ? v.periph : (v.periph ^ 32'h5A5A_0000 ^ 32'(i));
        end
        if (v.exp_slot >= 0) hits_expected++;
        chk("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        vectors++;
        // Request inputs change after acceptance; they must be ignored.
        req_valid = 1'b0;
        req_write = ~v.write;
        req_addr  = $urandom;
        req_wdata = $urandom;
        resp_ready = (v.delay == 0);
        chk("access_we", 32'(sl_we), v.write ? 32'(exp_oh) : 32'h0);
        chk("access_re", 32'(sl_re), v.write ? 32'h0 : 32'(exp_oh));
        chk("access_wdata", sl_wdata, v.write ? v.wdata : 32'h0);
        chk("access_req_ready", 32'(req_ready), 32'h0);
        chk("access_resp_valid", 32'(resp_valid), 32'h0);
        strobe_seen += $countones({sl_we, sl_re});
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'h1);
        chk("resp_rdata", resp_rdata, v.exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(v.exp_err));
        chk("resp_strobes", 32'({sl_we, sl_re}), 32'h0);
        chk("resp_wdata", sl_wdata, 32'h0);
        chk("resp_req_ready", 32'(req_ready), 32'h0);
        for (int d = 0; d < v.delay; d++) begin
            // A competing request while the response is held must not be accepted.
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = BASE;
            req_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("hold_resp_valid", 32'(resp_valid), 32'h1);
            chk("hold_rdata", resp_rdata, v.exp_rdata);
            chk("hold_err", 32'(resp_err), 32'(v.exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'h0);
            chk("hold_strobes", 32'({sl_we, sl_re}), 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("done_resp_valid", 32'(resp_valid), 32'h0);
        chk("done_req_ready", 32'(req_ready), 32'h1);
        chk("done_strobes", 32'({sl_we, sl_re}), 32'h0);
        resp_ready = 1'b0;
    endtask

    initial begin
        vec_t        rv;
        int          sel;
        vectors = 0; miscompares = 0; n_checks = 0; strobe_seen = 0; hits_expected = 0;
        for (int i = 0; i < NS; i++) periph_val[i] = 32'h0;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;

        // write, addr, wdata, periph, delay, exp_slot, exp_rdata, exp_err
        tbl[0] = '{1'b1, 32'h1000_1000, 32'h0000_00A5, 32'h0, 0, 1, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 32'h1000_1000, 32'h0, 32'h0000_00A5, 0, 1, 32'h0000_00A5, 1'b0};
        tbl[2] = '{1'b0, 32'h1000_4000, 32'h0, 32'h1111_2222, 0, -1, MissRd, ErrEn};
        tbl[3] = '{1'b0, 32'h1000_3FFC, 32'h0, 32'h1234_5678, 0, 3, 32'h1234_5678, 1'b0};
        tbl[4] = '{1'b0, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 1'b0};
        tbl[5] = '{1'b1, 32'h0FFF_FFFC, 32'h3333_4444, 32'h0, 0, -1, 32'h0, ErrEn};
        tbl[6] = '{1'b0, 32'h1000_2004, 32'h0, 32'h7654_3210, 5, 2, 32'h7654_3210, 1'b0};
        tbl[7] = '{1'b0, 32'h1000_2002, 32'h0, 32'h0BAD_CAFE, 0, ErrEn ? -1 : 2,
                   ErrEn ? MissRd : 32'h0BAD_CAFE, ErrEn};
        tbl[8] = '{1'b1, 32'hFFFF_FFFC, 32'h5555_6666, 32'h0, 2, -1, 32'h0, ErrEn};

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_strobes", 32'({sl_we, sl_re}), 32'h0);
        chk("rst_wdata", sl_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        for (int t = 0; t < 9; t++) run_txn(tbl[t]);

        // Reset during ACCESS of a store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_2000; req_wdata = 32'h77;
        @(negedge clk);
        vectors++;
        req_valid = 1'b0;
        chk("rstmid_we_before", 32'(sl_we), 32'h4);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_we_dropped", 32'(sl_we), 32'h0);
        chk("rstmid_wdata", sl_wdata, 32'h0);
        @(negedge clk);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_resp_after", 32'(resp_valid), 32'h0);
        chk("rstmid_req_ready", 32'(req_ready), 32'h1);
        run_txn(tbl[3]);

        // Random stream against the arithmetic model.
        for (int n = 0; n < 1000; n++) begin
            rv.write = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 6) rv.addr = BASE + 32'($urandom_range(0, NS * 4096 + 4095));
            else if (sel < 8) rv.addr = BASE - 32'($urandom_range(1, 64));
            else rv.addr = $urandom;
            rv.wdata  = $urandom;
            rv.periph = $urandom;
            rv.delay  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            rv.exp_slot = model_slot(rv.addr);
            if (rv.write) rv.exp_rdata = 32'h0;
            else if (rv.exp_slot >= 0) rv.exp_rdata = rv.periph;
            else rv.exp_rdata = MissRd;
            rv.exp_err = ErrEn && (rv.exp_slot < 0);
            run_txn(rv);
        end

        chk("strobe_count", 32'(strobe_seen), 32'(hits_expected));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
